axi_tlb_cfg_seq: RTL and testbench

- AXI4-Lite master sequencer that programs `axi_tlb` L1 entries through the TLB configuration port.
- Converts one-shot entry-update or flush commands into ordered register writes. Ordering: invalidate first, payload next, valid flag last. Software and DMA engines therefore never observe a torn entry.
- Sits between the system control logic and the `axi_tlb` `cfg_req_i`/`cfg_resp_o` port; allows exactly one outstanding write.

---
 rtl/axi_tlb_cfg_seq.sv | 329 ++++++++++++++++++++++++++++++++
 tb/tb_axi_tlb_cfg_seq.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_tlb_cfg_seq.sv
// axi_tlb_cfg_seq
//   AXI4-Lite master sequencer that programs axi_tlb L1 entries through the
//   TLB configuration port. A one-shot command becomes an ordered series of
//   single-beat writes: the entry is invalidated first, then first/last/base
//   are written in ascending address order, and the flags word (valid,
//   read_only) is written last, so no observer ever sees a torn entry.
//   A flush writes flags=0 to every entry and keeps going past errors.
//   Exactly one write is outstanding at any time.
//
// Optional feature (macro AXI_TLB_CFG_SEQ_READBACK_EN):
//   After the final flags write of an entry command succeeds, the flags word
//   is read back and compared; a bad response or mismatch sets the error.
//   Without the macro the AR/R channels are tied off.
//
// Ports:
//   clk_i, rst_ni         clock, asynchronous active-low reset
//   req_valid_i/ready_o   command handshake
//   req_flush_i           1: invalidate all entries, 0: write entry req_idx_i
//   req_idx_i             entry index
//   req_first_i/last_i    input page range
//   req_base_i            output base page
//   req_entry_valid_i     valid flag to program
//   req_read_only_i       read-only flag to program
//   rsp_valid_o/ready_i   completion handshake
//   rsp_err_o             any error during the command
//   rsp_idx_o             index of the completed command (0 for flush)
//   cfg_req_o/cfg_resp_i  AXI4-Lite master port towards the TLB config port

`timescale 1ns/1ps

package axi_tlb_cfg_seq_pkg;
    typedef struct packed {
        logic [31:0] addr;
        logic [2:0]  prot;
    } aw_chan_t;
    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  strb;
    } w_chan_t;
    typedef struct packed {
        logic [1:0] resp;
    } b_chan_t;
    typedef struct packed {
        logic [31:0] addr;
        logic [2:0]  prot;
    } ar_chan_t;
    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  resp;
    } r_chan_t;
    typedef struct packed {
        aw_chan_t aw;
        logic     aw_valid;
        w_chan_t  w;
        logic     w_valid;
        logic     b_ready;
        ar_chan_t ar;
        logic     ar_valid;
        logic     r_ready;
    } lite_req_t;
    typedef struct packed {
        logic    aw_ready;
        logic    w_ready;
        b_chan_t b;
        logic    b_valid;
        logic    ar_ready;
        r_chan_t r;
        logic    r_valid;
    } lite_resp_t;
endpackage

module axi_tlb_cfg_seq #(
    parameter int unsigned                CfgAxiAddrWidth = 32,
    parameter int unsigned                CfgAxiDataWidth = 32,
    parameter int unsigned                NumEntries      = 8,
    parameter int unsigned                IdxWidth        = 4,
    parameter int unsigned                PageNumWidth    = 52,
    parameter logic [CfgAxiAddrWidth-1:0] BaseAddr        = '0,
    parameter type                        lite_req_t      = axi_tlb_cfg_seq_pkg::lite_req_t,
    parameter type                        lite_resp_t     = axi_tlb_cfg_seq_pkg::lite_resp_t
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    req_valid_i,
    output logic                    req_ready_o,
    input  logic                    req_flush_i,
    input  logic [IdxWidth-1:0]     req_idx_i,
    input  logic [PageNumWidth-1:0] req_first_i,
    input  logic [PageNumWidth-1:0] req_last_i,
    input  logic [PageNumWidth-1:0] req_base_i,
    input  logic                    req_entry_valid_i,
    input  logic                    req_read_only_i,
    output logic                    rsp_valid_o,
    input  logic                    rsp_ready_i,
    output logic                    rsp_err_o,
    output logic [IdxWidth-1:0]     rsp_idx_o,
    output lite_req_t               cfg_req_o,
    input  lite_resp_t              cfg_resp_i
);

    localparam int unsigned NumBeats  = (CfgAxiDataWidth == 32) ? 8 : 5;
    localparam int unsigned MaxCnt    = (NumBeats > NumEntries) ? NumBeats : NumEntries;
    localparam int unsigned BeatWidth = $clog2(MaxCnt);
    localparam logic [7:0]  FlagsOff  = 8'h18;

    typedef enum logic [2:0] {
        StIdle,
        StIssue,
        StWaitB,
`ifdef AXI_TLB_CFG_SEQ_READBACK_EN
        StRdAr,
        StRdR,
`endif
        StResp
    } state_e;

    state_e                      state_q, state_d;
    logic [BeatWidth-1:0]        beat_q, beat_d;
    logic                        aw_done_q, aw_done_d;
    logic                        w_done_q, w_done_d;
    logic                        err_q, err_d;
    logic                        flush_q, flush_d;
    logic [IdxWidth-1:0]         idx_q, idx_d;
    logic [63:0]                 first_q, first_d;
    logic [63:0]                 last_q, last_d;
    logic [63:0]                 base_q, base_d;
    logic [1:0]                  flags_q, flags_d;

    logic [BeatWidth-1:0]        last_beat;
    logic [31:0]                 entry_num;
    logic [CfgAxiAddrWidth-1:0]  entry_base;
    logic [CfgAxiAddrWidth-1:0]  beat_addr;
    logic [7:0]                  beat_off;
    logic [63:0]                 beat_data;
    logic [31:0]                 payload_idx;
    logic [31:0]                 field_sel;
    logic                        word_hi;
    logic [63:0]                 field_val;
    logic                        req_oor;
    logic                        aw_fin, w_fin, b_err;

    assign req_oor    = !req_flush_i && (32'(req_idx_i) >= NumEntries);
    assign last_beat  = flush_q ? BeatWidth'(NumEntries - 1) : BeatWidth'(NumBeats - 1);
    // During a flush the beat counter doubles as the entry index.
    assign entry_num  = flush_q ? 32'(beat_q) : 32'(idx_q);
    assign entry_base = BaseAddr + (CfgAxiAddrWidth'(entry_num) << 5);
    assign beat_addr  = entry_base + CfgAxiAddrWidth'(beat_off);

    // Beat 0 and the last beat hit the flags word; beats in between walk the
    // 64-bit payload fields in ascending address order (two words each at DW=32).
    always_comb begin
        beat_off    = FlagsOff;
        beat_data   = '0;
        payload_idx = '0;
        field_sel   = '0;
        word_hi     = 1'b0;
        field_val   = '0;
        if (!flush_q) begin
            if (beat_q == last_beat) begin
                beat_data = {62'b0, flags_q};
            end else if (beat_q != '0) begin
                payload_idx = 32'(beat_q) - 32'd1;
                if (CfgAxiDataWidth == 32) begin
                    field_sel = payload_idx >> 1;
                    word_hi   = payload_idx[0];
                    beat_off  = 8'(payload_idx << 2);
                end else begin
                    field_sel = payload_idx;
                    beat_off  = 8'(payload_idx << 3);
                end
                case (field_sel)
                    32'd0:   field_val = first_q;
                    32'd1:   field_val = last_q;
                    default: field_val = base_q;
                endcase
                if (CfgAxiDataWidth == 32) begin
                    beat_data = word_hi ? {32'b0, field_val[63:32]} : {32'b0, field_val[31:0]};
                end else begin
                    beat_data = field_val;
                end
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        beat_d      = beat_q;
        aw_done_d   = aw_done_q;
        w_done_d    = w_done_q;
        err_d       = err_q;
        flush_d     = flush_q;
        idx_d       = idx_q;
        first_d     = first_q;
        last_d      = last_q;
        base_d      = base_q;
        flags_d     = flags_q;
        aw_fin      = 1'b0;
        w_fin       = 1'b0;
        b_err       = 1'b0;
        req_ready_o = 1'b0;
        rsp_valid_o = 1'b0;

        cfg_req_o         = '0;
        cfg_req_o.aw.addr = beat_addr;
        cfg_req_o.w.data  = CfgAxiDataWidth'(beat_data);
        cfg_req_o.w.strb  = '1;
`ifdef AXI_TLB_CFG_SEQ_READBACK_EN
        cfg_req_o.ar.addr = entry_base + CfgAxiAddrWidth'(FlagsOff);
`endif

        unique case (state_q)
            StIdle: begin
                req_ready_o = 1'b1;
                if (req_valid_i) begin
                    flush_d   = req_flush_i;
                    idx_d     = req_flush_i ? '0 : req_idx_i;
                    first_d   = 64'(req_first_i);
                    last_d    = 64'(req_last_i);
                    base_d    = 64'(req_base_i);
                    flags_d   = {req_read_only_i, req_entry_valid_i};
                    beat_d    = '0;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    err_d     = req_oor;
                    state_d   = req_oor ? StResp : StIssue;
                end
            end
            StIssue: begin
                cfg_req_o.aw_valid = !aw_done_q;
                cfg_req_o.w_valid  = !w_done_q;
                // Each channel is retired by its own handshake and never re-raised.
                aw_fin = aw_done_q || cfg_resp_i.aw_ready;
                w_fin  = w_done_q || cfg_resp_i.w_ready;
                if (aw_fin && w_fin) begin
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = StWaitB;
                end else begin
                    aw_done_d = aw_fin;
                    w_done_d  = w_fin;
                end
            end
            StWaitB: begin
                cfg_req_o.b_ready = 1'b1;
                if (cfg_resp_i.b_valid) begin
                    b_err = (cfg_resp_i.b.resp != '0);
                    if (b_err && !flush_q) begin
                        // Abort: the entry is left invalid by the earlier flags=0 write.
                        err_d   = 1'b1;
                        state_d = StResp;
                    end else begin
                        err_d = err_q || b_err;
                        if (beat_q == last_beat) begin
`ifdef AXI_TLB_CFG_SEQ_READBACK_EN
                            state_d = flush_q ? StResp : StRdAr;
`else
                            state_d = StResp;
`endif
                        end else begin
                            beat_d  = beat_q + 1'b1;
                            state_d = StIssue;
                        end
                    end
                end
            end
`ifdef AXI_TLB_CFG_SEQ_READBACK_EN
            StRdAr: begin
                cfg_req_o.ar_valid = 1'b1;
                if (cfg_resp_i.ar_ready) begin
                    state_d = StRdR;
                end
            end
            StRdR: begin
                cfg_req_o.r_ready = 1'b1;
                if (cfg_resp_i.r_valid) begin
                    if ((cfg_resp_i.r.resp != '0) || (cfg_resp_i.r.data[1:0] != flags_q)) begin
                        err_d = 1'b1;
                    end
                    state_d = StResp;
                end
            end
`endif
            StResp: begin
                rsp_valid_o = 1'b1;
                if (rsp_ready_i) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign rsp_err_o = err_q;
    assign rsp_idx_o = idx_q;

    logic unused_rd;
    assign unused_rd = ^{cfg_resp_i.r.data, cfg_resp_i.r.resp, cfg_resp_i.ar_ready, cfg_resp_i.r_valid};

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= StIdle;
            beat_q    <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            err_q     <= 1'b0;
            flush_q   <= 1'b0;
            idx_q     <= '0;
            first_q   <= '0;
            last_q    <= '0;
            base_q    <= '0;
            flags_q   <= '0;
        end else begin
            state_q   <= state_d;
            beat_q    <= beat_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            err_q     <= err_d;
            flush_q   <= flush_d;
            idx_q     <= idx_d;
            first_q   <= first_d;
            last_q    <= last_d;
            base_q    <= base_d;
            flags_q   <= flags_d;
        end
    end

endmodule

// File: tb/tb_axi_tlb_cfg_seq.sv
`timescale 1ns/1ps
module tb_axi_tlb_cfg_seq;
    import axi_tlb_cfg_seq_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_flush;
    logic [3:0]  req_idx;
    logic [51:0] req_first, req_last, req_base;
    logic        req_ev, req_ro;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [3:0]  rsp_idx;
    lite_req_t   cfg_req;
    lite_resp_t  cfg_resp;

    always #5 clk = ~clk;

    axi_tlb_cfg_seq #(
        .CfgAxiAddrWidth (32),
        .CfgAxiDataWidth (32),
        .NumEntries      (8),
        .IdxWidth        (4),
        .PageNumWidth    (52),
        .BaseAddr        (32'h1000),
        .lite_req_t      (lite_req_t),
        .lite_resp_t     (lite_resp_t)
    ) u_dut (
        .clk_i             (clk),
        .rst_ni            (rst_n),
        .req_valid_i       (req_valid),
        .req_ready_o       (req_ready),
        .req_flush_i       (req_flush),
        .req_idx_i         (req_idx),
        .req_first_i       (req_first),
        .req_last_i        (req_last),
        .req_base_i        (req_base),
        .req_entry_valid_i (req_ev),
        .req_read_only_i   (req_ro),
        .rsp_valid_o       (rsp_valid),
        .rsp_ready_i       (rsp_ready),
        .rsp_err_o         (rsp_err),
        .rsp_idx_o         (rsp_idx),
        .cfg_req_o         (cfg_req),
        .cfg_resp_i        (cfg_resp)
    );

    int n_vec = 0;
    int n_err = 0;

    // Slave knobs, written only by the stimulus block.
    int          aw_lat  = 0;
    int          w_lat   = 0;
    int          err_b   = -1;
    logic [31:0] rd_data = 32'h1;

    // Slave state, written only by the slave block.
    logic [31:0] aw_log [0:127];
    logic [31:0] w_log  [0:127];
    int aw_cnt = 0, w_cnt = 0, b_cnt = 0, age = 0, bad_fixed = 0, bad_rd = 0;
    bit aw_seen, w_seen, b_hs, ar_seen, r_hs;

    // Expected write list for the current check.
    logic [31:0] exp_a [0:7];
    logic [31:0] exp_d [0:7];

    // Config-port slave. Decisions are made on the falling edge, so a ready
    // driven here while valid is high is a handshake at the next rising edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            cfg_resp = '0;
            aw_seen  = 0; w_seen = 0; b_hs = 0; age = 0; ar_seen = 0; r_hs = 0;
        end else begin
            if (b_hs) begin
                cfg_resp.b_valid = 1'b0;
                b_hs = 0; aw_seen = 0; w_seen = 0; age = 0;
            end else if (aw_seen && w_seen) begin
                cfg_resp.b_valid = 1'b1;
                cfg_resp.b.resp  = (b_cnt == err_b) ? 2'b10 : 2'b00;
                if (cfg_req.b_ready) begin
                    b_hs = 1;
                    b_cnt++;
                end
            end
            cfg_resp.aw_ready = 1'b0;
            cfg_resp.w_ready  = 1'b0;
            if (cfg_req.aw_valid && !aw_seen && age >= aw_lat) begin
                cfg_resp.aw_ready = 1'b1;
                aw_seen = 1;
                if (aw_cnt < 128) aw_log[aw_cnt] = cfg_req.aw.addr;
                if (cfg_req.aw.prot != 3'b000) bad_fixed++;
                aw_cnt++;
            end
            if (cfg_req.w_valid && !w_seen && age >= w_lat) begin
                cfg_resp.w_ready = 1'b1;
                w_seen = 1;
                if (w_cnt < 128) w_log[w_cnt] = cfg_req.w.data;
                if (cfg_req.w.strb != 4'hF) bad_fixed++;
                w_cnt++;
            end
            if (cfg_req.aw_valid || cfg_req.w_valid) age++;
`ifdef AXI_TLB_CFG_SEQ_READBACK_EN
            if (r_hs) begin
                cfg_resp.r_valid = 1'b0;
                r_hs = 0; ar_seen = 0;
            end else if (ar_seen) begin
                cfg_resp.r_valid = 1'b1;
                cfg_resp.r.data  = rd_data;
                cfg_resp.r.resp  = 2'b00;
                if (cfg_req.r_ready) r_hs = 1;
            end
            cfg_resp.ar_ready = 1'b0;
            if (cfg_req.ar_valid && !ar_seen) begin
                cfg_resp.ar_ready = 1'b1;
                ar_seen = 1;
            end
`else
            if (cfg_req.ar_valid || cfg_req.r_ready) bad_rd++;
`endif
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Presents one command and returns at the falling edge of the first cycle after the handshake.
    task automatic send(input string tag, input logic flush, input logic [3:0] idx,
                        input logic [51:0] f, input logic [51:0] l, input logic [51:0] b,
                        input logic ev, input logic ro);
        @(negedge clk);
        req_valid = 1'b1; req_flush = flush; req_idx = idx;
        req_first = f; req_last = l; req_base = b; req_ev = ev; req_ro = ro;
        chk({tag, "_req_ready"}, req_ready, 1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_rsp(input string tag, input int hold, input logic exp_err,
                            input logic [3:0] exp_idx, output int lat);
        lat = 1;
        while (rsp_valid !== 1'b1 && lat < 400) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, "_rsp_valid"}, rsp_valid, 1);
        chk({tag, "_rsp_err"}, rsp_err, exp_err);
        chk({tag, "_rsp_idx"}, rsp_idx, exp_idx);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk({tag, "_hold_valid"}, rsp_valid, 1);
            chk({tag, "_hold_err"}, rsp_err, exp_err);
            chk({tag, "_hold_idx"}, rsp_idx, exp_idx);
            chk({tag, "_hold_req_ready"}, req_ready, 0);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        @(negedge clk);
        chk({tag, "_idle_again"}, req_ready, 1);
        chk({tag, "_rsp_dropped"}, rsp_valid, 0);
    endtask

    task automatic check_writes(input string tag, input int sa, input int sw, input int n);
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s_aw%0d", tag, i), aw_log[sa + i], exp_a[i]);
            chk($sformatf("%s_w%0d", tag, i), w_log[sw + i], exp_d[i]);
        end
    endtask

    int sa, sw, sb, lat;

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; req_flush = 1'b0; req_idx = '0;
        req_first = '0; req_last = '0; req_base = '0; req_ev = 1'b0; req_ro = 1'b0;
        rsp_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_req_ready", req_ready, 1);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_err", rsp_err, 0);
        chk("rst_rsp_idx", rsp_idx, 0);
        chk("rst_aw_valid", cfg_req.aw_valid, 0);
        chk("rst_w_valid", cfg_req.w_valid, 0);
        chk("rst_b_ready", cfg_req.b_ready, 0);
        chk("rst_ar_valid", cfg_req.ar_valid, 0);
        chk("rst_r_ready", cfg_req.r_ready, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Entry write idx=2: invalidate, payload words, then flags.
        exp_a = '{32'h1058, 32'h1040, 32'h1044, 32'h1048, 32'h104C, 32'h1050, 32'h1054, 32'h1058};
        exp_d = '{32'h0, 32'h10, 32'h0, 32'h1F, 32'h0, 32'h80, 32'h0, 32'h1};
        sa = aw_cnt; sw = w_cnt;
        rd_data = 32'h1;
        send("t1", 1'b0, 4'd2, 52'h10, 52'h1F, 52'h80, 1'b1, 1'b0);
        chk("t1_aw_first_cycle", cfg_req.aw_valid, 1);
        wait_rsp("t1", 0, 1'b0, 4'd2, lat);
        chk("t1_aw_count", aw_cnt - sa, 8);
        chk("t1_w_count", w_cnt - sw, 8);
        check_writes("t1", sa, sw, 8);

        // SLVERR on the third B aborts the entry write; response held 5 cycles.
        sa = aw_cnt; sw = w_cnt;
        err_b = b_cnt + 2;
        send("t2", 1'b0, 4'd2, 52'h10, 52'h1F, 52'h80, 1'b1, 1'b0);
        wait_rsp("t2", 5, 1'b1, 4'd2, lat);
        chk("t2_aw_count", aw_cnt - sa, 3);
        chk("t2_w_count", w_cnt - sw, 3);
        err_b = -1;

        // Flush: flags=0 to every entry, response index forced to 0.
        for (int e = 0; e < 8; e++) begin
            exp_a[e] = 32'h1018 + 32'(e) * 32'd32;
            exp_d[e] = 32'h0;
        end
        sa = aw_cnt; sw = w_cnt;
        send("t3", 1'b1, 4'd5, 52'h0, 52'h0, 52'h0, 1'b0, 1'b0);
        wait_rsp("t3", 0, 1'b0, 4'd0, lat);
        chk("t3_aw_count", aw_cnt - sa, 8);
        check_writes("t3", sa, sw, 8);

        // Flush with SLVERR on entry 3 still visits all entries.
        sa = aw_cnt; sw = w_cnt;
        err_b = b_cnt + 3;
        send("t4", 1'b1, 4'd0, 52'h0, 52'h0, 52'h0, 1'b0, 1'b0);
        wait_rsp("t4", 0, 1'b1, 4'd0, lat);
        chk("t4_aw_count", aw_cnt - sa, 8);
        check_writes("t4", sa, sw, 8);
        err_b = -1;

        // Out-of-range index: no bus access, quick error response.
        sa = aw_cnt;
        send("t5", 1'b0, 4'd9, 52'h1, 52'h2, 52'h3, 1'b1, 1'b0);
        chk("t5_no_aw_valid", cfg_req.aw_valid, 0);
        wait_rsp("t5", 0, 1'b1, 4'd9, lat);
        chk("t5_latency_le2", lat <= 2, 1);
        chk("t5_aw_count", aw_cnt - sa, 0);

        // W ready in cycle 1, AW ready in cycle 4; also exercises upper words.
        exp_a = '{32'h10F8, 32'h10E0, 32'h10E4, 32'h10E8, 32'h10EC, 32'h10F0, 32'h10F4, 32'h10F8};
        exp_d = '{32'h0, 32'h01234567, 32'h000ABCDE, 32'h1, 32'h0, 32'hFFFFFFFF, 32'h000FFFFF, 32'h2};
        sa = aw_cnt; sw = w_cnt; sb = b_cnt;
        w_lat = 0; aw_lat = 3; rd_data = 32'h2;
        send("t6", 1'b0, 4'd7, 52'hA_BCDE_0123_4567, 52'h1, 52'hF_FFFF_FFFF_FFFF, 1'b0, 1'b1);
        chk("t6_c1_aw_valid", cfg_req.aw_valid, 1);
        chk("t6_c1_w_valid", cfg_req.w_valid, 1);
        for (int c = 2; c <= 4; c++) begin
            @(negedge clk);
            chk($sformatf("t6_c%0d_w_low", c), cfg_req.w_valid, 0);
            chk($sformatf("t6_c%0d_aw_high", c), cfg_req.aw_valid, 1);
        end
        @(negedge clk);
        chk("t6_c5_aw_low", cfg_req.aw_valid, 0);
        chk("t6_c5_w_low", cfg_req.w_valid, 0);
        chk("t6_c5_b_ready", cfg_req.b_ready, 1);
        wait_rsp("t6", 0, 1'b0, 4'd7, lat);
        chk("t6_w_count", w_cnt - sw, 8);
        chk("t6_b_count", b_cnt - sb, 8);
        check_writes("t6", sa, sw, 8);
        w_lat = 0; aw_lat = 0;

`ifdef AXI_TLB_CFG_SEQ_READBACK_EN
        // Readback returns 0 after programming valid=1.
        rd_data = 32'h0;
        send("t7", 1'b0, 4'd1, 52'h4, 52'h5, 52'h6, 1'b1, 1'b0);
        wait_rsp("t7", 0, 1'b1, 4'd1, lat);
        rd_data = 32'h1;
`endif

        chk("fixed_fields", bad_fixed, 0);
        chk("rd_tied_off", bad_rd, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
